// File: rtl/uart_program_loader_pkg.sv
// Shared types for the UART program loader: loader and receiver state encodings,
// and the byte order used when packing received bytes into instruction words.
package uart_program_loader_pkg;

  typedef enum logic [1:0] {
    S_HDR,
    S_DATA,
    S_DONE,
    S_ERR
  } load_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam bit BIG_ENDIAN = 1'b1;

  // First byte of a word lands in bits [31:24] when big-endian.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] w, input logic [7:0] b);
    return BIG_ENDIAN ? {w[23:0], b} : {b, w[31:8]};
  endfunction

endpackage

// File: rtl/uart_program_loader_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, start-bit qualification at half a bit,
// mid-bit sampling, and one-cycle byte_valid / frame_err pulses on the stop bit.
module uart_rx_byte
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       rx_active
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s2_q && rx_prev_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s2_q) byte_valid_d = 1'b1;
          else         frame_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_s1_q      <= rx;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = frame_err_q;
  assign rx_active  = (state_q == RX_DATA) || (state_q == RX_STOP);

endmodule

// File: rtl/uart_program_loader.sv
// Loads a program image (count header + N big-endian words) from a UART line into
// instruction memory, then raises LOAD_DONE; any framing or count error latches LOAD_ERR.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 200
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              UART_RX,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  output logic              BUSY,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  logic       byte_valid, frame_err, rx_active;
  logic [7:0] byte_data;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (CLK),
    .rst        (RST),
    .rx         (UART_RX),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err),
    .rx_active  (rx_active)
  );

  load_state_e       state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic              word_valid_q, word_valid_d;
  logic [31:0]       n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    n_d          = n_q;
    addr_d       = addr_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    if (byte_valid) begin
      word_d       = shift_in_byte(word_q, byte_data);
      byte_cnt_d   = byte_cnt_q + 2'd1;
      word_valid_d = (byte_cnt_q == 2'd3);
    end

    case (state_q)
      S_HDR: begin
        if (frame_err) begin
          state_d = S_ERR;
        end else if (word_valid_q) begin
          n_d    = word_q;
          addr_d = '0;
          if (word_q == 32'd0)                  state_d = S_DONE;
          else if (word_q > 32'(MAX_WORDS))     state_d = S_ERR;
          else                                  state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (frame_err) begin
          state_d = S_ERR;
        end else if (word_valid_q) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = word_q;
          addr_d      = addr_q + ADDR_W'(1);
          // Full 32-bit compare: N is bounded by MAX_WORDS so addr never wraps.
          if (32'(addr_q) == n_q - 32'd1) state_d = S_DONE;
        end
      end
      default: ;
    endcase

    if (state_d == S_DONE || state_d == S_ERR) busy_d = 1'b0;
    else if (rx_active)                        busy_d = 1'b1;
    else                                       busy_d = busy_q;
    done_d = done_q | (state_d == S_DONE);
    err_d  = err_q  | (state_d == S_ERR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_HDR;
      byte_cnt_q   <= '0;
      word_valid_q <= 1'b0;
      n_q          <= '0;
      addr_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_valid_q <= word_valid_d;
      n_q          <= n_d;
      addr_q       <= addr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    word_q <= word_d;
  end

  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign BUSY      = busy_q;
  assign LOAD_DONE = done_q;
  assign LOAD_ERR  = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader at 16 clocks per bit.
module tb_uart_program_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        UART_RX = 1'b1;
  logic        MEM_WE;
  logic [7:0]  MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic        BUSY, LOAD_DONE, LOAD_ERR;

  int compared = 0;
  int mismatched = 0;
  int we_cnt = 0;
  logic [7:0]  wa [8];
  logic [31:0] wd [8];

  uart_program_loader #(
    .CLK_HZ(1_600_000), .BAUD(100_000), .ADDR_W(8), .MAX_WORDS(200)
  ) dut (
    .CLK(CLK), .RST(RST), .UART_RX(UART_RX),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .BUSY(BUSY), .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (MEM_WE === 1'b1) begin
      if (we_cnt < 8) begin
        wa[we_cnt] = MEM_ADDR;
        wd[we_cnt] = MEM_WDATA;
      end
      we_cnt = we_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input bit probe);
    @(negedge CLK);
    UART_RX = 1'b0;
    repeat (16) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (16) @(negedge CLK);
    end
    UART_RX = stop;
    if (probe) begin
      repeat (4) @(negedge CLK);
      check("done_before_stop_sample", 32'(LOAD_DONE), 32'd0);
      repeat (12) @(negedge CLK);
    end else begin
      repeat (16) @(negedge CLK);
    end
    UART_RX = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit probe_last);
    send_byte(w[31:24], 1'b1, 1'b0);
    send_byte(w[23:16], 1'b1, 1'b0);
    send_byte(w[15:8],  1'b1, 1'b0);
    send_byte(w[7:0],   1'b1, probe_last);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    UART_RX = 1'b1;
    RST = 1'b1;
    we_cnt = 0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_we",    32'(MEM_WE),    32'd0);
    check("rst_addr",  32'(MEM_ADDR),  32'd0);
    check("rst_wdata", MEM_WDATA,      32'd0);
    check("rst_busy",  32'(BUSY),      32'd0);
    check("rst_done",  32'(LOAD_DONE), 32'd0);
    check("rst_err",   32'(LOAD_ERR),  32'd0);
    do_reset();

    // 1: two-word image
    send_word(32'h0000_0002, 1'b0);
    check("t1_busy_after_hdr", 32'(BUSY), 32'd1);
    check("t1_done_after_hdr", 32'(LOAD_DONE), 32'd0);
    send_word(32'h2008_0005, 1'b0);
    send_word(32'hAC08_0000, 1'b0);
    repeat (4) @(negedge CLK);
    check("t1_we_count", 32'(we_cnt), 32'd2);
    check("t1_addr0",  32'(wa[0]), 32'd0);
    check("t1_data0",  wd[0], 32'h2008_0005);
    check("t1_addr1",  32'(wa[1]), 32'd1);
    check("t1_data1",  wd[1], 32'hAC08_0000);
    check("t1_done",   32'(LOAD_DONE), 32'd1);
    check("t1_busy",   32'(BUSY), 32'd0);
    check("t1_err",    32'(LOAD_ERR), 32'd0);
    check("t1_we_idle", 32'(MEM_WE), 32'd0);
    check("t1_wdata_hold", MEM_WDATA, 32'hAC08_0000);
    send_byte(8'h55, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    check("t1_no_write_after_done", 32'(we_cnt), 32'd2);
    check("t1_done_sticky", 32'(LOAD_DONE), 32'd1);
    check("t1_frame_err_ignored_in_done", 32'(LOAD_ERR), 32'd0);

    // 2: empty image
    do_reset();
    send_word(32'h0000_0000, 1'b1);
    check("t2_done", 32'(LOAD_DONE), 32'd1);
    check("t2_busy", 32'(BUSY), 32'd0);
    check("t2_err",  32'(LOAD_ERR), 32'd0);
    check("t2_we_count", 32'(we_cnt), 32'd0);

    // 3: count above MAX_WORDS
    do_reset();
    send_word(32'h0000_00C9, 1'b0);
    repeat (4) @(negedge CLK);
    check("t3_err",  32'(LOAD_ERR), 32'd1);
    check("t3_done", 32'(LOAD_DONE), 32'd0);
    check("t3_busy", 32'(BUSY), 32'd0);
    check("t3_we_count", 32'(we_cnt), 32'd0);

    // 4: framing error on byte 2 of data word 0
    do_reset();
    send_word(32'h0000_0001, 1'b0);
    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    send_byte(8'h56, 1'b1, 1'b0);
    send_byte(8'h78, 1'b1, 1'b0);
    repeat (4) @(negedge CLK);
    check("t4_err",  32'(LOAD_ERR), 32'd1);
    check("t4_done", 32'(LOAD_DONE), 32'd0);
    check("t4_we_count", 32'(we_cnt), 32'd0);

    // 5: 4-clock glitch while idle, then a 1-word image
    do_reset();
    @(negedge CLK);
    UART_RX = 1'b0;
    repeat (4) @(negedge CLK);
    UART_RX = 1'b1;
    repeat (40) @(negedge CLK);
    check("t5_glitch_busy", 32'(BUSY), 32'd0);
    check("t5_glitch_done", 32'(LOAD_DONE), 32'd0);
    check("t5_glitch_err",  32'(LOAD_ERR), 32'd0);
    send_word(32'h0000_0001, 1'b0);
    send_word(32'h1234_5678, 1'b0);
    repeat (4) @(negedge CLK);
    check("t5_we_count", 32'(we_cnt), 32'd1);
    check("t5_addr0", 32'(wa[0]), 32'd0);
    check("t5_data0", wd[0], 32'h1234_5678);
    check("t5_done",  32'(LOAD_DONE), 32'd1);

    // 6: reset mid-transfer, then a fresh 1-word image
    do_reset();
    send_word(32'h0000_0002, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'hBB, 1'b1, 1'b0);
    check("t6_first_write", wd[0], 32'hDEAD_BEEF);
    check("t6_busy_before_rst", 32'(BUSY), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("t6_rst_we",    32'(MEM_WE),    32'd0);
    check("t6_rst_addr",  32'(MEM_ADDR),  32'd0);
    check("t6_rst_wdata", MEM_WDATA,      32'd0);
    check("t6_rst_busy",  32'(BUSY),      32'd0);
    check("t6_rst_done",  32'(LOAD_DONE), 32'd0);
    check("t6_rst_err",   32'(LOAD_ERR),  32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    we_cnt = 0;
    repeat (4) @(negedge CLK);
    send_word(32'h0000_0001, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0);
    repeat (4) @(negedge CLK);
    check("t6_we_count", 32'(we_cnt), 32'd1);
    check("t6_addr0", 32'(wa[0]), 32'd0);
    check("t6_data0", wd[0], 32'hCAFE_F00D);
    check("t6_done",  32'(LOAD_DONE), 32'd1);
    check("t6_err",   32'(LOAD_ERR), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
